// File: rtl/uart_resp_tx.sv
// Buffered UART response transmitter: small byte FIFO feeding an 8N1 serializer.
// Define UART_RESP_TX_PARITY_EN to build 8E1 frames with an even parity bit.
module uart_resp_tx #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       fifo_full,
    output logic       busy,
    output logic       tx_done,
    output logic       ovr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

`ifdef UART_RESP_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          empty, full, push, pop;
    logic [7:0]    head;
    logic [8:0]    load;

    state_t        state_q, state_d;
    logic [8:0]    shift_q, shift_d;
    logic [11:0]   baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic          tick;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;

    // Fullness is taken from the registered pointers, so a push on a pop cycle while full is dropped.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = trmt && !full;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign tick  = (baud_q == BAUD_LAST);

`ifdef UART_RESP_TX_PARITY_EN
    assign load = {^head, head};
`else
    assign load = {1'b1, head};
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            shift_q  <= '1;
            baud_q   <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            shift_q  <= shift_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        baud_d  = (state_q == IDLE || tick) ? 12'd0 : baud_q + 12'd1;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = load;
                    baud_d  = 12'd0;
                    bit_d   = 4'd0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {1'b1, shift_q[8:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd7) begin
`ifdef UART_RESP_TX_PARITY_EN
                        state_d = PAR;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RESP_TX_PARITY_EN
            PAR: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next start bit when more bytes are queued.
                if (tick) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = load;
                        bit_d   = 4'd0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    // TX is registered from the next state so the line changes on the same edge as the FSM.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_RESP_TX_PARITY_EN
            PAR:     tx_d = shift_d[0];
`endif
            default: tx_d = 1'b1;
        endcase
        done_d = (state_q == STOP) && tick;
        ovr_d  = ovr_q || (trmt && full);
    end

    assign TX        = tx_q;
    assign fifo_full = full;
    assign busy      = (state_q != IDLE) || !empty;
    assign tx_done   = done_q;
    assign ovr       = ovr_q;

endmodule

// File: tb/tb_uart_resp_tx.sv
// Directed bench for uart_resp_tx with BAUD_DIV=8, FIFO_DEPTH=4.
// Frame length follows UART_RESP_TX_PARITY_EN when the bench is built with it.
module tb_uart_resp_tx;

    localparam int BAUD = 8;
`ifdef UART_RESP_TX_PARITY_EN
    localparam int  NBITS  = 11;
    localparam bit  PAR_EN = 1'b1;
`else
    localparam int  NBITS  = 10;
    localparam bit  PAR_EN = 1'b0;
`endif
    localparam int FRAME = NBITS * BAUD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trmt = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       TX, fifo_full, busy, tx_done, ovr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int doneQ[$];

    uart_resp_tx #(.BAUD_DIV(BAUD), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .TX       (TX),
        .fifo_full(fifo_full),
        .busy     (busy),
        .tx_done  (tx_done),
        .ovr      (ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done) doneQ.push_back(cyc);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h at cycle %0d", tag, observed, expected, cyc);
        end
    endtask

    task automatic stepTo(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at a negedge; returns at the following negedge with the push edge number.
    task automatic applyStimulus(input logic [7:0] d, output int edgeN);
        trmt    = 1'b1;
        tx_data = d;
        @(negedge clk);
        edgeN = cyc;
        trmt  = 1'b0;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic expBit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (PAR_EN && k == 9) return ^d;
        return 1'b1;
    endfunction

    // N is the edge that would push the byte from idle; the start bit begins after edge N+1.
    task automatic checkFrame(input string tag, input logic [7:0] d, input int n);
        if (cyc <= n + 1) begin
            stepTo(n + 1);
            checkOutput({tag, "_start_edge"}, TX, 0);
        end
        for (int k = 0; k < NBITS; k++) begin
            stepTo(n + 1 + BAUD * k + BAUD / 2);
            checkOutput($sformatf("%s_bit%0d", tag, k), TX, expBit(d, k));
        end
    endtask

    task automatic checkDone(input string tag, input int first, input int count);
        checkOutput({tag, "_done_count"}, doneQ.size(), count);
        for (int i = 0; i < doneQ.size() && i < count; i++) begin
            checkOutput($sformatf("%s_done%0d", tag, i), doneQ[i], first + FRAME * i);
        end
    endtask

    initial begin
        int n, m, dummy;
        @(negedge clk);
        applyReset();
        checkOutput("rst_TX", TX, 1);
        checkOutput("rst_full", fifo_full, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", tx_done, 0);
        checkOutput("rst_ovr", ovr, 0);

        // Single byte
        doneQ.delete();
        applyStimulus(8'hA5, n);
        checkOutput("single_TX_before", TX, 1);
        checkOutput("single_busy", busy, 1);
        checkFrame("single", 8'hA5, n);
        stepTo(n + FRAME + 1);
        checkOutput("single_busy_end", busy, 0);
        stepTo(n + FRAME + 3);
        checkDone("single", n + FRAME + 1, 1);

        // Burst of four consecutive pushes
        doneQ.delete();
        applyStimulus(8'h00, n);
        checkOutput("burst_full0", fifo_full, 0);
        applyStimulus(8'hFF, dummy);
        checkOutput("burst_full1", fifo_full, 0);
        applyStimulus(8'h55, dummy);
        checkOutput("burst_full2", fifo_full, 0);
        applyStimulus(8'h3C, dummy);
        checkOutput("burst_full3", fifo_full, 0);
        checkFrame("burst0", 8'h00, n);
        checkFrame("burst1", 8'hFF, n + FRAME);
        checkFrame("burst2", 8'h55, n + 2 * FRAME);
        checkFrame("burst3", 8'h3C, n + 3 * FRAME);
        stepTo(n + 4 * FRAME + 3);
        checkDone("burst", n + FRAME + 1, 4);
        checkOutput("burst_ovr", ovr, 0);
        checkOutput("burst_busy_end", busy, 0);

        // Overrun: four queued behind an in-flight frame, fifth dropped
        doneQ.delete();
        applyStimulus(8'h11, n);
        stepTo(n + 10);
        applyStimulus(8'h21, dummy);
        applyStimulus(8'h22, dummy);
        applyStimulus(8'h23, dummy);
        checkOutput("ovr_full3", fifo_full, 0);
        applyStimulus(8'h24, dummy);
        checkOutput("ovr_full4", fifo_full, 1);
        checkOutput("ovr_before", ovr, 0);
        applyStimulus(8'h25, dummy);
        checkOutput("ovr_set", ovr, 1);
        checkOutput("ovr_full5", fifo_full, 1);
        stepTo(n + FRAME);
        checkOutput("ovr_full_prepop", fifo_full, 1);
        stepTo(n + FRAME + 1);
        checkOutput("ovr_full_postpop", fifo_full, 0);
        checkFrame("ovr1", 8'h21, n + FRAME);
        checkFrame("ovr2", 8'h22, n + 2 * FRAME);
        checkFrame("ovr3", 8'h23, n + 3 * FRAME);
        checkFrame("ovr4", 8'h24, n + 4 * FRAME);
        stepTo(n + 5 * FRAME + 20);
        checkDone("ovr", n + FRAME + 1, 5);
        checkOutput("ovr_sticky", ovr, 1);
        checkOutput("ovr_busy_end", busy, 0);

        // Full FIFO with a push on the STOP pop cycle
        applyReset();
        checkOutput("col_ovr_cleared", ovr, 0);
        doneQ.delete();
        applyStimulus(8'h31, n);
        stepTo(n + 10);
        applyStimulus(8'h41, dummy);
        applyStimulus(8'h42, dummy);
        applyStimulus(8'h43, dummy);
        applyStimulus(8'h44, dummy);
        checkOutput("col_full", fifo_full, 1);
        stepTo(n + FRAME);
        checkOutput("col_ovr_before", ovr, 0);
        applyStimulus(8'h55, dummy);
        checkOutput("col_ovr_set", ovr, 1);
        checkOutput("col_full_after", fifo_full, 0);
        checkFrame("col1", 8'h41, n + FRAME);
        checkFrame("col2", 8'h42, n + 2 * FRAME);
        checkFrame("col3", 8'h43, n + 3 * FRAME);
        checkFrame("col4", 8'h44, n + 4 * FRAME);
        stepTo(n + 5 * FRAME + 20);
        checkDone("col", n + FRAME + 1, 5);

        // Reset during data bit 3 of 0x81 with a second byte queued
        doneQ.delete();
        applyStimulus(8'h81, n);
        applyStimulus(8'h99, dummy);
        stepTo(n + 1 + BAUD * 4 + 2);
        checkOutput("mid_TX_bit3", TX, 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_TX", TX, 1);
        checkOutput("mid_busy", busy, 0);
        checkOutput("mid_full", fifo_full, 0);
        rst = 1'b0;
        stepTo(n + 2 * FRAME + 20);
        checkOutput("mid_no_done", doneQ.size(), 0);
        checkOutput("mid_TX_idle", TX, 1);
        applyStimulus(8'h12, m);
        checkFrame("after_rst", 8'h12, m);
        stepTo(m + FRAME + 3);
        checkDone("after_rst", m + FRAME + 1, 1);

        // Parity-sensitive bytes (odd and even weight)
        doneQ.delete();
        applyStimulus(8'h07, n);
        checkFrame("b07", 8'h07, n);
        stepTo(n + FRAME + 3);
        checkDone("b07", n + FRAME + 1, 1);
        doneQ.delete();
        applyStimulus(8'h03, n);
        checkFrame("b03", 8'h03, n);
        stepTo(n + FRAME + 3);
        checkDone("b03", n + FRAME + 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
